// File: rtl/blinky_multi.sv
// rtl/blinky_multi.sv - multi-mode LED blinker for the ULX3S top level
//
// Purpose:
//   Drives an LED bank in one of four button-selectable display modes
//   (button follow, binary count, bouncing scan, PWM breathe), paced by a
//   configurable tick prescaler. Also holds the ESP32 boot strap high.
//
// Parameters:
//   LEDS        width of led, 2..32
//   DIV         tick period in clocks, >= 2
//   DEB_CYCLES  stable clocks needed to accept a button change, >= 1
//               (only meaningful when BLINKY_DEBOUNCE_EN is defined)
//
// Compile-time option:
//   BLINKY_DEBOUNCE_EN  adds a per-button debounce counter behind the
//                       synchronizer; without it the synchronizer output
//                       is used directly and button bounce is visible.
//
// Ports:
//   clk_25mhz   in   1     sole clock
//   rst_n       in   1     asynchronous assert, active-low reset
//   btn         in   7     raw buttons, active-high
//                          btn[1] mode advance, btn[2] pause,
//                          btn[i] mirrored on led[i] in FOLLOW mode
//   led         out  LEDS  registered LED drive
//   mode        out  2     current display mode (debug)
//   wifi_gpio0  out  1     constant 1, also during reset

module blinky_multi #(
  parameter int LEDS       = 8,
  parameter int DIV        = 12_500_000,
  parameter int DEB_CYCLES = 250_000
) (
  input  logic            clk_25mhz,
  input  logic            rst_n,
  input  logic [6:0]      btn,
  output logic [LEDS-1:0] led,
  output logic [1:0]      mode,
  output logic            wifi_gpio0
);

  typedef enum logic [1:0] {
    M_FOLLOW  = 2'd0,
    M_COUNT   = 2'd1,
    M_SCAN    = 2'd2,
    M_BREATHE = 2'd3
  } mode_t;

  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  // Highest led index that mirrors a button in FOLLOW mode.
  localparam int            NF        = (LEDS - 1 < 6) ? LEDS - 1 : 6;

  // The ESP32 must see GPIO0 high at all times or it enters its bootloader.
  assign wifi_gpio0 = 1'b1;

  // --------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------
  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [6:0] acc;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef BLINKY_DEBOUNCE_EN
  localparam int            DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [7];

  // A bit is accepted once the synchronized value has disagreed with the
  // accepted value for DEB_CYCLES clocks in a row; any agreeing clock
  // restarts the count, so short glitches never reach acc.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      for (int i = 0; i < 7; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          acc[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end
`else
  assign acc = sync2;
`endif

  // acc[0] and, for narrow banks, the upper buttons are not displayed.
  logic unused_acc;
  assign unused_acc = ^acc;

  // --------------------------------------------------------------------
  // Press detect and pause
  // --------------------------------------------------------------------
  logic acc1_q;
  logic press;
  logic pause;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      acc1_q <= 1'b0;
    end else begin
      acc1_q <= acc[1];
    end
  end

  assign press = acc[1] & ~acc1_q;
  assign pause = acc[2];

  // --------------------------------------------------------------------
  // Mode register
  // --------------------------------------------------------------------
  mode_t mode_q;
  mode_t mode_d;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_FOLLOW;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (press) begin
      mode_d = mode_t'(mode_q + 2'd1);
    end
  end

  assign mode = mode_q;

  // --------------------------------------------------------------------
  // Tick prescaler
  // --------------------------------------------------------------------
  logic [PW-1:0] pcnt;
  logic          tick;

  // Pause gates the tick as well as the counter so a paused prescaler
  // parked on its last value cannot keep firing.
  assign tick = ~pause && (pcnt == PCNT_LAST);

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (press) begin
      // Restart the tick phase so every mode begins with a full period.
      pcnt <= '0;
    end else if (!pause) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

  // --------------------------------------------------------------------
  // Per-mode state
  // --------------------------------------------------------------------
  logic            blink;
  logic [LEDS-1:0] cnt;
  logic [LEDS-1:0] pos;
  logic            pos_up;
  logic [3:0]      duty;
  logic            duty_up;
  logic [3:0]      pwm;

  // A press takes priority over a coincident tick: the new mode starts
  // from its initial state and that tick is dropped.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      blink   <= 1'b0;
      cnt     <= '0;
      pos     <= LEDS'(1);
      pos_up  <= 1'b1;
      duty    <= 4'd0;
      duty_up <= 1'b1;
    end else if (press) begin
      blink   <= 1'b0;
      cnt     <= '0;
      pos     <= LEDS'(1);
      pos_up  <= 1'b1;
      duty    <= 4'd0;
      duty_up <= 1'b1;
    end else if (tick) begin
      case (mode_q)
        M_FOLLOW: begin
          blink <= ~blink;
        end
        M_COUNT: begin
          cnt <= cnt + LEDS'(1);
        end
        M_SCAN: begin
          // Reverse at the end bits so neither end is lit twice in a row.
          if (pos_up) begin
            if (pos[LEDS-1]) begin
              pos_up <= 1'b0;
              pos    <= {1'b0, pos[LEDS-1:1]};
            end else begin
              pos <= {pos[LEDS-2:0], 1'b0};
            end
          end else begin
            if (pos[0]) begin
              pos_up <= 1'b1;
              pos    <= {pos[LEDS-2:0], 1'b0};
            end else begin
              pos <= {1'b0, pos[LEDS-1:1]};
            end
          end
        end
        M_BREATHE: begin
          // Triangle 0..15..0 without repeating the peaks: 30 ticks.
          if (duty_up) begin
            if (duty == 4'd15) begin
              duty_up <= 1'b0;
              duty    <= 4'd14;
            end else begin
              duty <= duty + 4'd1;
            end
          end else begin
            if (duty == 4'd0) begin
              duty_up <= 1'b1;
              duty    <= 4'd1;
            end else begin
              duty <= duty - 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // 16-clock PWM frame shared by all LEDs in BREATHE mode.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 4'd0;
    end else begin
      pwm <= pwm + 4'd1;
    end
  end

  // --------------------------------------------------------------------
  // LED decode and output register
  // --------------------------------------------------------------------
  logic [LEDS-1:0] led_d;

  always_comb begin
    led_d = '0;
    case (mode_q)
      M_FOLLOW: begin
        led_d[0] = blink;
        for (int i = 1; i <= NF; i++) begin
          led_d[i] = acc[i];
        end
      end
      M_COUNT: begin
        led_d = cnt;
      end
      M_SCAN: begin
        led_d = pos;
      end
      M_BREATHE: begin
        // duty 0 never lights; duty 15 lights 15 of 16 clocks.
        led_d = {LEDS{pwm < duty}};
      end
      default: begin
        led_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

endmodule

// File: tb/tb_blinky_multi.sv
// tb/tb_blinky_multi.sv - scoreboard testbench for blinky_multi
module tb_blinky_multi;

  localparam int LEDS = 4;
  localparam int DIV  = 4;
  localparam int DEB  = 3;

`ifdef BLINKY_DEBOUNCE_EN
  localparam int LAT  = 6;   // btn edge -> mode / FOLLOW led
  localparam int FROZ = 1;   // count value held while paused
  localparam int RL   = 9;   // pause release -> next count on led
  localparam int RES  = 2;
`else
  localparam int LAT  = 3;
  localparam int FROZ = 0;
  localparam int RL   = 5;
  localparam int RES  = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      btn;
  logic [LEDS-1:0] led;
  logic [1:0]      mode;
  logic            wifi_gpio0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [3:0] mask;
    logic [1:0] mode;
    string      name;
  } exp_t;

  exp_t sb[$];

  blinky_multi #(.LEDS(LEDS), .DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk_25mhz (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .led       (led),
    .mode      (mode),
    .wifi_gpio0(wifi_gpio0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [3:0] l, input logic [3:0] m,
                               input logic [1:0] md, input string nm);
    exp_t e;
    e.cyc  = c;
    e.led  = l;
    e.mask = m;
    e.mode = md;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Breathe model: led at cycle c shows (pwm < duty) as of cycle c-1.
  // pwm counts from reset release t0; tick n after mode entry at base
  // sets duty to the triangle value of n.
  function automatic logic [3:0] breathe_exp(input int c, input int t0, input int base);
    int pc;
    int pw;
    int n;
    int d;
    pc = c - 1;
    pw = (pc - t0) % 16;
    n  = ((pc - base) / 4) % 30;
    d  = (n <= 15) ? n : 30 - n;
    return (pw < d) ? 4'hF : 4'h0;
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every scheduled expectation on its cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s scheduled for cycle %0d but seen at %0d", sb[i].name, sb[i].cyc, cyc);
        end else if (((led & sb[i].mask) !== (sb[i].led & sb[i].mask)) ||
                     (mode !== sb[i].mode) || (wifi_gpio0 !== 1'b1)) begin
          errors++;
          $display("FAIL %s cyc=%0d got led=%h mode=%0d wifi=%b expected led=%h (mask %h) mode=%0d wifi=1",
                   sb[i].name, cyc, led, mode, wifi_gpio0, sb[i].led, sb[i].mask, sb[i].mode);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f, p, x, y, q, r, s, u, v;
    logic [3:0] scan_seq [8];
    scan_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

    rst_n = 1'b0;
    btn   = 7'd0;

    // Reset and first FOLLOW blink.
    goto(3);
    push(3, 4'h0, 4'hF, 2'd0, "reset");
    goto(4);
    rst_n = 1'b1;
    t0 = 4;
    push(t0 + 4, 4'h0, 4'hF, 2'd0, "blink_before");
    push(t0 + 5, 4'h1, 4'hF, 2'd0, "blink_on");
    push(t0 + 8, 4'h1, 4'hF, 2'd0, "blink_hold");
    push(t0 + 9, 4'h0, 4'hF, 2'd0, "blink_off");

    // FOLLOW button path.
    f = t0 + 10;
    goto(f);
    btn[3] = 1'b1;
    push(f + LAT - 1, 4'h0, 4'hE, 2'd0, "follow_early");
    push(f + LAT,     4'h8, 4'hE, 2'd0, "follow_set");
    goto(f + 8);
    btn[3] = 1'b0;
    push(f + 8 + LAT, 4'h0, 4'hE, 2'd0, "follow_clear");
    goto(f + 16);

`ifdef BLINKY_DEBOUNCE_EN
    // Short glitch must be rejected.
    btn[1] = 1'b1;
    push(f + 22, 4'h0, 4'h2, 2'd0, "glitch_led");
    push(f + 28, 4'h0, 4'h0, 2'd0, "glitch_mode");
    goto(f + 18);
    btn[1] = 1'b0;
    p = f + 30;
`else
    p = f + 16;
`endif

    // COUNT.
    push(p + LAT - 1, 4'h0, 4'h0, 2'd0, "mode_before");
    push(p + LAT,     4'h0, 4'h0, 2'd1, "mode_count");
    for (int n = 0; n <= 16; n++) begin
      push(p + LAT + 1 + 4 * n, 4'(n % 16), 4'hF, 2'd1, "count");
    end
    goto(p);
    btn[1] = 1'b1;
    goto(p + 4);
    btn[1] = 1'b0;

    // Pause and resume.
    x = p + LAT + 64;
    y = x + 20;
    goto(x);
    btn[2] = 1'b1;
    push(x + 10,     4'(FROZ), 4'hF, 2'd1, "pause_held");
    push(x + 20,     4'(FROZ), 4'hF, 2'd1, "pause_held_late");
    push(y + RL - 1, 4'(FROZ), 4'hF, 2'd1, "resume_before");
    push(y + RL,     4'(RES),  4'hF, 2'd1, "resume_step");
    goto(y);
    btn[2] = 1'b0;

    // SCAN.
    q = y + 12;
    push(q + LAT, 4'h0, 4'h0, 2'd2, "mode_scan");
    for (int n = 0; n < 8; n++) begin
      push(q + LAT + 1 + 4 * n, scan_seq[n], 4'hF, 2'd2, "scan");
    end
    goto(q);
    btn[1] = 1'b1;
    goto(q + 4);
    btn[1] = 1'b0;

    // BREATHE, cycle-accurate over a full triangle.
    r = q + 40;
    push(r + LAT, 4'h0, 4'h0, 2'd3, "mode_breathe");
    for (int c = r + LAT + 1; c <= r + LAT + 130; c++) begin
      push(c, breathe_exp(c, t0, r + LAT), 4'hF, 2'd3, "breathe");
    end
    goto(r);
    btn[1] = 1'b1;
    goto(r + 4);
    btn[1] = 1'b0;

    // Press landing on a tick edge: advance wins, FOLLOW starts fresh.
    s = r + 132;
    push(s + LAT - 1, 4'h0, 4'h0, 2'd3, "wrap_before");
    push(s + LAT,     4'h0, 4'h0, 2'd0, "wrap_mode");
    push(s + LAT + 1, 4'h0, 4'h1, 2'd0, "wrap_blink0");
    push(s + LAT + 4, 4'h0, 4'h1, 2'd0, "wrap_blink_hold");
    push(s + LAT + 5, 4'h1, 4'h1, 2'd0, "wrap_blink_tick");
    goto(s);
    btn[1] = 1'b1;
    goto(s + 4);
    btn[1] = 1'b0;

    // Reset asserted while in COUNT.
    u = s + LAT + 8;
    v = u + LAT + 10;
    push(v - 1, 4'h0, 4'h0, 2'd1, "pre_reset_mode");
    push(v,     4'h0, 4'hF, 2'd0, "midreset");
    push(v + 3, 4'h0, 4'hF, 2'd0, "midreset_hold");
    push(v + 8, 4'h0, 4'hF, 2'd0, "rerelease_before");
    push(v + 9, 4'h1, 4'hF, 2'd0, "rerelease_blink");
    goto(u);
    btn[1] = 1'b1;
    goto(u + 4);
    btn[1] = 1'b0;
    goto(v);
    rst_n = 1'b0;
    goto(v + 4);
    rst_n = 1'b1;
    goto(v + 12);

    for (int k = 0; k < 50 && sb.size() > 0; k++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blinky_multi.md
# blinky_multi

Parametrised successor to the board-bringup blinker for the ULX3S top level. Drives an LED bank with four button-selectable display modes (button follow, binary count, bouncing scan, PWM breathe) from a configurable tick prescaler. Includes conditioned button inputs and keeps the ESP32 boot strap held high. Sits directly under the board top, between the `clk_25mhz`/`btn` pins and the `led`/`wifi_gpio0` pins.

## Interface

- `LEDS`, default 8: width of `led`, legal range 2..32.
- `DIV`, default 12_500_000: tick period in clocks, minimum 2.
- `DEB_CYCLES`, default 250_000: consecutive stable clocks required to accept a button change, minimum 1; used only with debounce compiled in.

Ports:
- `clk_25mhz`  in  1  sole clock; the block uses one clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn`  in  7  raw buttons, active-high. `btn[1]` = mode advance, `btn[2]` = pause, `btn[i]` shown in FOLLOW mode.
- `led`  out  LEDS  registered LED drive.
- `mode`  out  2  current mode register, for debug.
- `wifi_gpio0`  out  1  constant 1, including during reset.

## Operation

- Synchronizer: two flops per `btn` bit, reset 0. `acc` is the accepted button vector.
- Press pulse: 1-cycle pulse on a rising edge of `acc[1]`.
- Pause: `acc[2]`=1 freezes the prescaler; no ticks are issued.
- Prescaler: `pcnt` counts 0..DIV-1, then wraps. `tick`=1 for the single cycle with `pcnt`==DIV-1. Reset value 0.
- Mode register, reset 0 (FOLLOW). A press advances 0→1→2→3→0.
  - On advance: the mode's state resets to its initial value and `pcnt` is reset to 0.
  - If a press and a tick occur in the same cycle, the advance wins and the tick is discarded.
- Mode state changes only on cycles with `tick`=1:
  - 0 FOLLOW: `blink` flag toggles each tick (initial 0).
    - `led[0]`=`blink`.
    - `led[i]`=`acc[i]` for 1≤i≤min(6,LEDS-1).
    - Remaining bits are 0.
  - 1 COUNT: `led`=`cnt`, incremented per tick, initial 0. Wraps from 2^LEDS-1 to 0.
  - 2 SCAN: one-hot `pos`, initial bit 0, direction up.
    - Moves one bit per tick.
    - At bit LEDS-1 the direction reverses, so the next tick lights bit LEDS-2. Bit 0 behaves symmetrically.
    - No bit is repeated at the ends.
  - 3 BREATHE: `duty` 0..15, initial 0, direction up.
    - Steps ±1 per tick as a triangle (0..15..0), 30-tick period.
    - `pwm` is a 4-bit counter, free-running every clock, reset 0.
    - All `led` bits = (`pwm` < `duty`). `duty`=0 gives always off; `duty`=15 gives 15/16 duty.
- Reset mid-operation clears all state immediately, asynchronously:
  - `led`=0, `mode`=0, `cnt`=0, `pos`=1, `duty`=0, `blink`=0.
  - `wifi_gpio0` stays 1.

## Timing

- `led` is a flop loaded every clock from a decode of the current state: one cycle after any state change.
- Tick to LED:
  - A state update happens on the edge where `tick`=1.
  - `led` reflects it one edge later.
  - After reset release, the first FOLLOW toggle of `led[0]` is at rising edge DIV+1.
- Button latency, without debounce: `btn` change → `acc` at edge 2 → `led` (FOLLOW) at edge 3.
- Button latency, with debounce: `acc` updates at edge 2+DEB_CYCLES → `led` at edge 3+DEB_CYCLES.
- Mode latency: `mode` updates on the edge after `acc[1]` rises.
- BREATHE PWM period: 16 clocks.

## Configuration

- `BLINKY_DEBOUNCE_EN` defined:
  - Per-bit debounce counter behind the synchronizer.
  - `acc[i]` takes the synchronized value only after it has differed from `acc[i]` for DEB_CYCLES consecutive clocks.
  - Any agreeing cycle clears that bit's counter.
  - Counters and `acc` reset to 0.
- Not defined:
  - `acc` is the second synchronizer flop directly.
  - No debounce logic is present and DEB_CYCLES is ignored.
  - Bounce produces multiple presses.

## Test plan

Bench parameters: LEDS=4, DIV=4, DEB_CYCLES=3. Run with and without `BLINKY_DEBOUNCE_EN` unless stated.

- Reset: hold `rst_n`=0 → `led`=0, `mode`=0, `wifi_gpio0`=1. Release → `led[0]` 0→1 at edge 5, 1→0 at edge 9.
- FOLLOW path: set `btn[3]`=1 → `led[3]`=1 at edge 3 (no debounce) or edge 6 (debounce).
- Debounce (macro defined only): 2-cycle pulse on `btn[1]` → `mode` stays 0. Pulse held ≥4 cycles → `mode`=1.
- COUNT / pause:
  - In mode 1, `led` steps 0,1,..,15,0 every 4 clocks.
  - Hold `btn[2]`=1 → `led` frozen.
  - Release → counting resumes from the held value.
- SCAN / wrap: in mode 2 over successive ticks, `led` = 1,2,4,8,4,2,1,2.
- BREATHE and mode wrap:
  - Mode 3: measured `led` high count per 16 clocks equals `duty` (0,1,..,15,14,..).
  - A press issued in the same cycle as `tick` → `mode`=0 and no tick is applied.
  - Assert `rst_n` mid-mode → all outputs return to reset values.
